// File: rtl/defunnel_pkg.sv
// Shared types and helpers for the defunnel control stage.
// Slot geometry, reduct legality and per-beat slot masks live here.
package defunnel_pkg;

  localparam int CHUNKS = 8;
  localparam int STEPS  = 3;

  typedef logic [STEPS-1:0] reduct_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  function automatic logic reduct_legal(input reduct_t r);
    return (r == reduct_t'(1)) || (r == reduct_t'(2)) || (r == reduct_t'(4));
  endfunction

  // Anything outside {1,2,4} falls back to one chunk per beat.
  function automatic reduct_t reduct_eff(input reduct_t r);
    return reduct_legal(r) ? r : reduct_t'(1);
  endfunction

  function automatic logic [CHUNKS-1:0] slot_mask(input reduct_t reduct,
                                                  input logic [STEPS-1:0] beat);
    logic [CHUNKS-1:0] base;
    base = CHUNKS'((1 << reduct) - 1);
    return base << (int'(beat) * int'(reduct));
  endfunction

endpackage

// File: rtl/defunnel_beat_cnt.sv
// Beat-within-frame wrap counter with beats-per-frame decode from reduct.
// A frame closes on its last beat or on an early close request.
module defunnel_beat_cnt
  import defunnel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_i,
  input  logic             close_i,
  input  reduct_t          reduct_i,
  output logic [STEPS-1:0] beat_o,
  output logic             last_beat_o,
  output logic             done_o
);

  logic [STEPS-1:0] beat_q;
  logic [STEPS-1:0] beat_d;
  logic [STEPS-1:0] last_idx;

  always_comb begin
    last_idx = STEPS'(CHUNKS - 1);
    if (reduct_i == reduct_t'(2)) begin
      last_idx = STEPS'(CHUNKS / 2 - 1);
    end else if (reduct_i == reduct_t'(4)) begin
      last_idx = STEPS'(CHUNKS / 4 - 1);
    end
  end

  assign last_beat_o = (beat_q == last_idx);
  assign done_o      = acc_i & (close_i | last_beat_o);

  always_comb begin
    beat_d = beat_q;
    if (done_o) begin
      beat_d = '0;
    end else if (acc_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/defunnel_ctl.sv
// Sequencer for the defunnel datapath: narrow beats in, slot strobes out, wide word handshake.
// Optional sticky protocol error flag is built when DEFUNNEL_CTL_ERR_EN is defined.
module defunnel_ctl #(
  parameter int CHUNKS = defunnel_pkg::CHUNKS,
  parameter int STEPS  = defunnel_pkg::STEPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_valid,
  output logic              t_ready,
  input  logic              t_last,
  input  logic [7:0]        t_cfg_dat,
  output logic [7:0]        cfg_dat,
  output logic [CHUNKS-1:0] enable,
  output logic [STEPS-1:0]  beat,
  output logic              i_valid,
  input  logic              i_ready,
  output logic              err
);

  import defunnel_pkg::*;

  state_t     state_q;
  logic       i_valid_q;
  logic [7:0] cfg_q;

  reduct_t    raw_reduct;
  reduct_t    reduct;
  logic       acc;
  logic       done;
  logic       last_beat;

  // Ready depends only on state and downstream ready, never on t_valid.
  assign t_ready    = (state_q == ST_FILL) | i_ready;
  assign acc        = t_valid & t_ready;
  assign cfg_dat    = (beat == '0) ? t_cfg_dat : cfg_q;
  assign raw_reduct = cfg_dat[STEPS-1:0];
  assign reduct     = reduct_eff(raw_reduct);
  assign enable     = acc ? slot_mask(reduct, beat) : '0;

  defunnel_beat_cnt u_beat_cnt (
    .clk         (clk),
    .reset       (reset),
    .acc_i       (acc),
    .close_i     (t_last),
    .reduct_i    (reduct),
    .beat_o      (beat),
    .last_beat_o (last_beat),
    .done_o      (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FILL;
      i_valid_q <= 1'b0;
      cfg_q     <= 8'h01;
    end else begin
      if (acc && (beat == '0)) begin
        cfg_q <= t_cfg_dat;
      end
      unique case (state_q)
        ST_FILL: begin
          if (done) begin
            i_valid_q <= 1'b1;
            state_q   <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A frame completing in the same cycle as the handoff keeps the word valid.
          if (i_ready && !done) begin
            i_valid_q <= 1'b0;
            state_q   <= ST_FILL;
          end
        end
        default: begin
          state_q   <= ST_FILL;
          i_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_valid = i_valid_q;

`ifdef DEFUNNEL_CTL_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = acc & (((beat == '0) & ~reduct_legal(raw_reduct)) | (t_last != last_beat));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_defunnel_ctl.sv
// Scoreboard bench for defunnel_ctl: directed test-plan sequences followed by random traffic.
module tb_defunnel_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_valid;
  logic       t_ready;
  logic       t_last;
  logic [7:0] t_cfg_dat;
  logic [7:0] cfg_dat;
  logic [7:0] enable;
  logic [2:0] beat;
  logic       i_valid;
  logic       i_ready;
  logic       err;

  always #5 clk = ~clk;

  defunnel_ctl dut (
    .clk       (clk),
    .reset     (reset),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .t_last    (t_last),
    .t_cfg_dat (t_cfg_dat),
    .cfg_dat   (cfg_dat),
    .enable    (enable),
    .beat      (beat),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .err       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q_en[$];
  logic [7:0] q_frame[$];

  logic       checks_on = 1'b0;
  logic       exp_ready;
  logic       exp_ivalid;
  logic       exp_err;
  int         exp_beat;
  logic [7:0] exp_cfg;

  // Reference model: frame position, frame size, pending-word flag.
  int         m_pos   = 0;
  int         m_nb    = 8;
  int         m_red   = 1;
  logic       m_full  = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_cfg   = 8'h01;
  logic [7:0] m_fmask = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] cfg, input logic last,
                      input logic ir, input logic rst);
    logic       acc;
    logic       done;
    logic [7:0] mask;
    int         raw;
    @(posedge clk);
    #1;
    reset     = rst;
    t_valid   = v;
    t_cfg_dat = cfg;
    t_last    = last;
    i_ready   = ir;
    exp_ready  = !m_full || ir;
    exp_ivalid = m_full;
    exp_err    = m_err;
    exp_beat   = m_pos;
    exp_cfg    = (m_pos == 0) ? cfg : m_cfg;
    acc  = v && exp_ready;
    done = 1'b0;
    if (acc) begin
      if (m_pos == 0) begin
        raw     = int'(cfg[2:0]);
        m_red   = (raw == 1 || raw == 2 || raw == 4) ? raw : 1;
        m_nb    = 8 / m_red;
        m_cfg   = cfg;
        m_fmask = 8'h00;
`ifdef DEFUNNEL_CTL_ERR_EN
        if (m_red != raw) m_err = 1'b1;
`endif
      end
      mask = 8'(((1 << m_red) - 1) << (m_pos * m_red));
      q_en.push_back(mask);
      m_fmask |= mask;
      done = last || (m_pos == m_nb - 1);
`ifdef DEFUNNEL_CTL_ERR_EN
      if (last != (m_pos == m_nb - 1)) m_err = 1'b1;
`endif
      m_pos = done ? 0 : m_pos + 1;
    end
    if (done) q_frame.push_back(m_fmask);
    m_full = done || (m_full && !ir);
    if (rst) begin
      m_pos   = 0;
      m_full  = 1'b0;
      m_err   = 1'b0;
      m_cfg   = 8'h01;
      m_fmask = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle status checks, slot strobes and completed words from the queues.
  logic       prev_iv  = 1'b0;
  logic       prev_hs  = 1'b0;
  logic [7:0] obs_mask = 8'h00;

  always @(negedge clk) begin
    if (checks_on) begin
      check("t_ready", t_ready, exp_ready);
      check("i_valid", i_valid, exp_ivalid);
      check("beat", beat, exp_beat);
      check("cfg_dat", cfg_dat, exp_cfg);
      check("err", err, exp_err);
      if (i_valid && (!prev_iv || prev_hs)) begin
        if (q_frame.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("frame_mask", obs_mask, q_frame.pop_front());
        end
        obs_mask = 8'h00;
      end
      if (enable != 8'h00) begin
        if (q_en.size() == 0) begin
          check("unexpected_enable", enable, 0);
        end else begin
          check("enable", enable, q_en.pop_front());
        end
        obs_mask |= enable;
      end
      if (reset) obs_mask = 8'h00;
      prev_iv = i_valid;
      prev_hs = i_valid && i_ready;
    end
  end

  initial begin
    logic       v;
    logic       lst;
    logic       ir;
    logic       rst;
    logic [7:0] cfg;
    logic [2:0] rsel;
    reset     = 1'b1;
    t_valid   = 1'b0;
    t_last    = 1'b0;
    t_cfg_dat = 8'h01;
    i_ready   = 1'b0;
    step(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    checks_on = 1'b1;
    idle(1);
    @(negedge clk);
    check("reset_enable", enable, 0);
    check("reset_t_ready", t_ready, 1);

    // reduct=4, two beats, consumer ready
    step(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
    idle(2);

    // reduct=1, mode change mid-frame must be ignored
    for (int i = 0; i < 8; i++) step(1'b1, (i >= 3) ? 8'h02 : 8'h01, 1'b0, 1'b1, 1'b0);
    idle(2);

    // back-pressure with reduct=2
    for (int i = 0; i < 4; i++) step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    idle(2);

    // back-to-back reduct=4 frames
    for (int i = 0; i < 6; i++) step(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
    idle(2);

    // early t_last on beat 1 of a reduct=2 frame
    step(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    idle(3);

    // illegal reduct=3, then reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h05, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h05, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("post_reset_beat", beat, 0);
    check("post_reset_ivalid", i_valid, 0);
    check("post_reset_err", err, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      v    = rst ? 1'b0 : ($urandom_range(0, 3) != 0);
      lst  = ($urandom_range(0, 9) == 0);
      ir   = ($urandom_range(0, 2) != 0);
      rsel = 3'($urandom_range(0, 7));
      cfg  = 8'($urandom);
      if (rsel < 3'd6) cfg[2:0] = (rsel < 3'd2) ? 3'd1 : (rsel < 3'd4) ? 3'd2 : 3'd4;
      step(v, cfg, lst, ir, rst);
    end
    idle(4);
    @(negedge clk);
    check("enable_queue_drained", q_en.size(), 0);
    check("frame_queue_drained", q_frame.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
